// File: rtl/risc_datapath.sv
// Single-bus 32-bit datapath for a 16-register load/store RISC, strobed cycle by cycle by an external controller.
// Define MULDIV_EN to build the signed multiplier/divider; otherwise opcodes 15/16 produce Z = 0.
module risc_datapath #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 9
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Read,
  input  logic                 Write,
  input  logic                 IncPC,
  input  logic [15:0]          R0_15_enable,
  input  logic [15:0]          R0_15_out,
  input  logic                 PCin,
  input  logic                 Zin,
  input  logic                 MDRin,
  input  logic                 MARin,
  input  logic                 Yin,
  input  logic                 HIin,
  input  logic                 LOin,
  input  logic                 IRin,
  input  logic                 OutPortin,
  input  logic                 PCout,
  input  logic                 Zhighout,
  input  logic                 Zlowout,
  input  logic                 HIout,
  input  logic                 LOout,
  input  logic                 MDRout,
  input  logic                 InPortout,
  input  logic                 Cout,
  input  logic                 BAout,
  input  logic                 CONin,
  input  logic                 Gra,
  input  logic                 Grb,
  input  logic                 Grc,
  input  logic                 Rin,
  input  logic                 Rout,
  input  logic [WIDTH-1:0]     InPort_input,
  input  logic [WIDTH-1:0]     Mdatain,
  output logic [WIDTH-1:0]     OutPort_out,
  output logic [ADDR_BITS-1:0] MAR_out,
  output logic [WIDTH-1:0]     MDR_out,
  output logic                 Mem_write,
  output logic [WIDTH-1:0]     Bus_out,
  output logic [WIDTH-1:0]     IR_out,
  output logic                 CON_out
);

  logic [15:0][WIDTH-1:0] r_R;
  logic [WIDTH-1:0]       r_PC, r_IR, r_MDR, r_Y, r_HI, r_LO, r_InPort, r_OutPort;
  logic [2*WIDTH-1:0]     r_Z;
  logic [ADDR_BITS-1:0]   r_MAR;
  logic                   r_CON;

  logic [4:0]       w_opcode;
  logic [3:0]       w_sel;
  logic [15:0]      w_onehot, w_ld, w_drv;
  logic [WIDTH-1:0] w_c, w_bus, w_alu_lo, w_alu_hi;
  logic [4:0]       w_sh;
  logic             w_cond;

  assign w_opcode = r_IR[31:27];
  assign w_sel    = ({4{Gra}} & r_IR[26:23]) | ({4{Grb}} & r_IR[22:19]) | ({4{Grc}} & r_IR[18:15]);
  assign w_onehot = 16'b1 << w_sel;
  assign w_ld     = R0_15_enable | ({16{Rin}} & w_onehot);
  assign w_drv    = R0_15_out | ({16{Rout | BAout}} & w_onehot);
  assign w_c      = {{(WIDTH-19){r_IR[18]}}, r_IR[18:0]};

  // Assignments run from lowest to highest priority so the last match wins.
  always_comb begin
    w_bus = '0;
    if (Cout)      w_bus = w_c;
    if (InPortout) w_bus = r_InPort;
    if (MDRout)    w_bus = r_MDR;
    if (PCout)     w_bus = r_PC;
    if (Zlowout)   w_bus = r_Z[WIDTH-1:0];
    if (Zhighout)  w_bus = r_Z[2*WIDTH-1:WIDTH];
    if (LOout)     w_bus = r_LO;
    if (HIout)     w_bus = r_HI;
    for (int i = 15; i >= 0; i--)
      if (w_drv[i]) w_bus = (i == 0 && BAout && w_sel == 4'd0) ? '0 : r_R[i];
  end

`ifdef MULDIV_EN
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_quo, w_rem;
  assign w_prod = $signed({{WIDTH{r_Y[WIDTH-1]}}, r_Y}) * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});
  assign w_quo  = $signed(r_Y) / $signed(w_bus);
  assign w_rem  = $signed(r_Y) % $signed(w_bus);
`endif

  assign w_sh = w_bus[4:0];

  always_comb begin
    w_alu_lo = w_bus;
    w_alu_hi = '0;
    case (w_opcode)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd19, 5'd21: w_alu_lo = r_Y + w_bus;
      5'd4:         w_alu_lo = r_Y - w_bus;
      5'd5, 5'd13:  w_alu_lo = r_Y & w_bus;
      5'd6, 5'd14:  w_alu_lo = r_Y | w_bus;
      5'd7:         w_alu_lo = 32'({r_Y, r_Y} >> w_sh);
      5'd8:         w_alu_lo = ({r_Y, r_Y} << w_sh) >> WIDTH;
      5'd9:         w_alu_lo = r_Y >> w_sh;
      5'd10:        w_alu_lo = $signed(r_Y) >>> w_sh;
      5'd11:        w_alu_lo = r_Y << w_sh;
`ifdef MULDIV_EN
      5'd15: begin
        w_alu_lo = w_prod[WIDTH-1:0];
        w_alu_hi = w_prod[2*WIDTH-1:WIDTH];
      end
      5'd16: begin
        // Divide by zero: all-ones quotient, dividend as remainder.
        w_alu_lo = (w_bus == '0) ? '1  : w_quo;
        w_alu_hi = (w_bus == '0) ? r_Y : w_rem;
      end
`else
      5'd15, 5'd16: w_alu_lo = '0;
`endif
      5'd17:        w_alu_lo = -w_bus;
      5'd18:        w_alu_lo = ~w_bus;
      default:      w_alu_lo = w_bus;
    endcase
  end

  always_comb begin
    case (r_IR[20:19])
      2'b00:   w_cond = (w_bus == '0);
      2'b01:   w_cond = (w_bus != '0);
      2'b10:   w_cond = ~w_bus[WIDTH-1];
      default: w_cond = w_bus[WIDTH-1];
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_R       <= '0;
      r_PC      <= '0;
      r_IR      <= '0;
      r_MAR     <= '0;
      r_MDR     <= '0;
      r_Y       <= '0;
      r_Z       <= '0;
      r_HI      <= '0;
      r_LO      <= '0;
      r_InPort  <= '0;
      r_OutPort <= '0;
      r_CON     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (w_ld[i]) r_R[i] <= w_bus;
      if (PCin)      r_PC      <= IncPC ? r_PC + 1'b1 : w_bus;
      if (IRin)      r_IR      <= w_bus;
      if (MARin)     r_MAR     <= w_bus[ADDR_BITS-1:0];
      if (MDRin)     r_MDR     <= Read ? Mdatain : w_bus;
      if (Yin)       r_Y       <= w_bus;
      if (Zin)       r_Z       <= {w_alu_hi, w_alu_lo};
      if (HIin)      r_HI      <= w_bus;
      if (LOin)      r_LO      <= w_bus;
      if (OutPortin) r_OutPort <= w_bus;
      if (CONin)     r_CON     <= w_cond;
      r_InPort <= InPort_input;
    end
  end

  assign OutPort_out = r_OutPort;
  assign MAR_out     = r_MAR;
  assign MDR_out     = r_MDR;
  assign Mem_write   = Write;
  assign Bus_out     = w_bus;
  assign IR_out      = r_IR;
  assign CON_out     = r_CON;

endmodule

// File: tb/tb_risc_datapath.sv
// Scoreboard bench for risc_datapath: expectations are queued when stimulus is driven and popped on observation.
module tb_risc_datapath;

  logic        Clock = 1'b0, Reset = 1'b0;
  logic        Read, Write, IncPC;
  logic [15:0] R0_15_enable, R0_15_out;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
  logic        CONin, Gra, Grb, Grc, Rin, Rout;
  logic [31:0] InPort_input = '0, Mdatain = '0;
  logic [31:0] OutPort_out, MDR_out, Bus_out, IR_out;
  logic [8:0]  MAR_out;
  logic        Mem_write, CON_out;

  typedef struct { string nm; logic [31:0] v; } exp_t;
  typedef struct { logic [4:0] op; logic [31:0] a, b, lo, hi; } alu_t;
  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_err = 0;

  risc_datapath dut (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .IncPC(IncPC),
    .R0_15_enable(R0_15_enable), .R0_15_out(R0_15_out),
    .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .IRin(IRin), .OutPortin(OutPortin), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .InPort_input(InPort_input), .Mdatain(Mdatain), .OutPort_out(OutPort_out),
    .MAR_out(MAR_out), .MDR_out(MDR_out), .Mem_write(Mem_write), .Bus_out(Bus_out),
    .IR_out(IR_out), .CON_out(CON_out)
  );

  always #5 Clock = ~Clock;

  task automatic clr();
    {Read, Write, IncPC, PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin} = '0;
    {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout} = '0;
    {CONin, Gra, Grb, Grc, Rin, Rout} = '0;
    R0_15_enable = '0;
    R0_15_out    = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clr();
  endtask

  task automatic ld_mdr(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v; step();
  endtask
  task automatic ld_reg(input int i, input logic [31:0] v);
    ld_mdr(v); MDRout = 1; R0_15_enable[i] = 1'b1; step();
  endtask
  task automatic ld_ir(input logic [31:0] v);
    ld_mdr(v); MDRout = 1; IRin = 1; step();
  endtask
  task automatic ld_y(input logic [31:0] v);
    ld_mdr(v); MDRout = 1; Yin = 1; step();
  endtask

  task automatic test_reset();
    clr();
    Reset = 0;
    #3 Reset = 1;
    #1;
    sb.push_back('{"rst_ir", 32'h0});
    sb.push_back('{"rst_con", 32'h0});
    sb.push_back('{"rst_outport", 32'h0});
    sb.push_back('{"rst_mar", 32'h0});
    e = sb.pop_front(); n_chk++; if (IR_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, IR_out, e.v); end
    e = sb.pop_front(); n_chk++; if ({31'b0, CON_out} !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, CON_out, e.v); end
    e = sb.pop_front(); n_chk++; if (OutPort_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, OutPort_out, e.v); end
    e = sb.pop_front(); n_chk++; if ({23'b0, MAR_out} !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, MAR_out, e.v); end
    PCout = 1; sb.push_back('{"rst_pc", 32'h0}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr(); Zlowout = 1; sb.push_back('{"rst_zlo", 32'h0}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
  endtask

  task automatic test_fetch();
    @(negedge Clock);
    PCout = 1; MARin = 1; IncPC = 1; sb.push_back('{"fetch_mar", 32'h0}); step();
    e = sb.pop_front(); n_chk++; if ({23'b0, MAR_out} !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, MAR_out, e.v); end
    PCin = 1; IncPC = 1; sb.push_back('{"fetch_pc", 32'h1}); step();
    PCout = 1; #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
    sb.push_back('{"fetch_mdr", 32'h611FFFFD}); ld_mdr(32'h611FFFFD);
    e = sb.pop_front(); n_chk++; if (MDR_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, MDR_out, e.v); end
    MDRout = 1; IRin = 1; sb.push_back('{"fetch_ir", 32'h611FFFFD}); step();
    e = sb.pop_front(); n_chk++; if (IR_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, IR_out, e.v); end
  endtask

  // IR still holds addi r2,r3,-3 from the fetch.
  task automatic test_addi();
    ld_reg(3, 32'd10);
    Grb = 1; Rout = 1; Yin = 1; step();
    Cout = 1; Zin = 1; step();
    Zhighout = 1; sb.push_back('{"addi_zhi", 32'h0}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
    Zlowout = 1; Gra = 1; Rin = 1; step();
    R0_15_out[2] = 1'b1; sb.push_back('{"addi_r2", 32'd7}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
  endtask

  task automatic test_ld();
    ld_reg(1, 32'h10);
    ld_reg(0, 32'h99);
    ld_ir(32'h00080045);
    Grb = 1; BAout = 1; Yin = 1; step();
    Cout = 1; Zin = 1; sb.push_back('{"ld_z", 32'h55}); step();
    Zlowout = 1; #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
    ld_ir(32'h00800075);
    Grb = 1; BAout = 1; sb.push_back('{"ba_r0_zero", 32'h0}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    Yin = 1; step();
    Cout = 1; Zin = 1; sb.push_back('{"ld_r0_z", 32'h75}); step();
    Zlowout = 1; #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
    Grb = 1; Rout = 1; sb.push_back('{"rout_r0", 32'h99}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
  endtask

  task automatic test_alu();
    alu_t t[$];
    t.push_back('{5'd3,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h0});
    t.push_back('{5'd4,  32'd5,        32'd7,        32'hFFFFFFFE, 32'h0});
    t.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0});
    t.push_back('{5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0});
    t.push_back('{5'd7,  32'h00000001, 32'd1,        32'h80000000, 32'h0});
    t.push_back('{5'd8,  32'h80000001, 32'd4,        32'h00000018, 32'h0});
    t.push_back('{5'd9,  32'h80000000, 32'd31,       32'h00000001, 32'h0});
    t.push_back('{5'd10, 32'h80000000, 32'd4,        32'hF8000000, 32'h0});
    t.push_back('{5'd11, 32'd3,        32'h21,       32'h00000006, 32'h0});
    t.push_back('{5'd17, 32'd0,        32'd5,        32'hFFFFFFFB, 32'h0});
    t.push_back('{5'd18, 32'd0,        32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0});
    t.push_back('{5'd20, 32'd9,        32'h12345678, 32'h12345678, 32'h0});
`ifdef MULDIV_EN
    t.push_back('{5'd15, 32'hFFFFFFFA, 32'd4,        32'hFFFFFFE8, 32'hFFFFFFFF});
    t.push_back('{5'd16, 32'd7,        32'd2,        32'd3,        32'd1});
    t.push_back('{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF});
    t.push_back('{5'd16, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9});
`else
    t.push_back('{5'd15, 32'hFFFFFFFA, 32'd4,        32'h0,        32'h0});
    t.push_back('{5'd16, 32'd7,        32'd2,        32'h0,        32'h0});
`endif
    foreach (t[k]) begin
      ld_ir({t[k].op, 27'b0});
      ld_y(t[k].a);
      ld_mdr(t[k].b);
      MDRout = 1; Zin = 1; step();
      sb.push_back('{$sformatf("alu%0d_hi", t[k].op), t[k].hi});
      sb.push_back('{$sformatf("alu%0d_lo", t[k].op), t[k].lo});
      Zhighout = 1; HIin = 1; step();
      Zlowout = 1; LOin = 1; step();
      HIout = 1; #1;
      e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
      clr(); LOout = 1; #1;
      e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
      clr();
    end
  endtask

  task automatic test_con();
    logic [1:0]  c2 [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] r5 [6] = '{32'd0, 32'd3, 32'd3, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] ex [6] = '{32'd1, 32'd0, 32'd1, 32'd0,        32'd1,        32'd0};
    for (int k = 0; k < 6; k++) begin
      ld_reg(5, r5[k]);
      ld_ir(32'h02800000 | {11'b0, c2[k], 19'b0});
      Gra = 1; Rout = 1; CONin = 1; sb.push_back('{$sformatf("con_%0d", k), ex[k]}); step();
      e = sb.pop_front(); n_chk++; if ({31'b0, CON_out} !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, CON_out, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    ld_reg(6, 32'hA5A5A5A5);
    R0_15_out[6] = 1'b1; R0_15_enable[6] = 1'b1; OutPortin = 1;
    sb.push_back('{"same_reg_bus", 32'hA5A5A5A5}); sb.push_back('{"outport", 32'hA5A5A5A5}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    step();
    e = sb.pop_front(); n_chk++; if (OutPort_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, OutPort_out, e.v); end
    ld_reg(1, 32'h11); ld_reg(2, 32'h22);
    ld_mdr(32'h40); MDRout = 1; PCin = 1; step();
    IncPC = 1; step();
    R0_15_out = 16'h0006; MDRout = 1; PCout = 1; sb.push_back('{"prio_r1", 32'h11}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr(); PCout = 1; MDRout = 1; InPortout = 1; Cout = 1; sb.push_back('{"prio_pc", 32'h40}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr(); Write = 1; sb.push_back('{"no_drive", 32'h0}); sb.push_back('{"mem_write", 32'h1}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    e = sb.pop_front(); n_chk++; if ({31'b0, Mem_write} !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Mem_write, e.v); end
    clr(); InPort_input = 32'hCAFEF00D; step();
    InPortout = 1; sb.push_back('{"inport", 32'hCAFEF00D}); #1;
    e = sb.pop_front(); n_chk++; if (Bus_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, Bus_out, e.v); end
    clr();
  endtask

  task automatic test_reset_mid();
    ld_ir(32'h12345678);
    ld_mdr(32'h5); MDRout = 1; OutPortin = 1; step();
    @(negedge Clock);
    Reset = 0; #1;
    sb.push_back('{"amid_ir", 32'h0}); sb.push_back('{"amid_out", 32'h0});
    e = sb.pop_front(); n_chk++; if (IR_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, IR_out, e.v); end
    e = sb.pop_front(); n_chk++; if (OutPort_out !== e.v) begin n_err++; $display("FAIL %s got %h exp %h", e.nm, OutPort_out, e.v); end
    Reset = 1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_addi();
    test_ld();
    test_alu();
    test_con();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
